// File: rtl/mesh_nic.sv
// mesh_nic: network interface between a processing element and the local
// port of its mesh router. One FIFO buffers PE-to-router injection traffic,
// another buffers router-to-PE ejection traffic. Injection, ejection and
// misroute counters are kept alongside.

// Single-clock FIFO with wrapping pointers and an occupancy count.
// Every output is derived from registered state only.
module mesh_nic_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             full;
    logic             empty;
    logic             push_fire;
    logic             pop_fire;

    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign push_ready = !full;
    assign pop_valid  = !empty;
    // A full FIFO refuses the push even when a pop happens in the same cycle,
    // so the freed slot only shows up as ready on the following cycle.
    assign push_fire = push_valid && !full;
    assign pop_fire  = pop_ready && !empty;
    // Head entry is masked to zero while empty so stale data never leaks out.
    assign pop_data  = empty ? '0 : mem[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; reset discards all buffered contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_fire) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (push_fire && !pop_fire)
                count_reg <= count_reg + (AW+1)'(1);
            else if (pop_fire && !push_fire)
                count_reg <= count_reg - (AW+1)'(1);
        end
    end

    // Storage array written on accepted pushes; not reset since emptiness masks it.
    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr_reg] <= push_data;
    end
endmodule

module mesh_nic #(
    parameter int PACKET_WIDTH = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int LOCAL_X      = 0,
    parameter int LOCAL_Y      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pe_send_in,
    output logic                    pe_ready_out,
    input  logic [PACKET_WIDTH-1:0] pe_data_in,
    output logic                    rt_send_out,
    input  logic                    rt_ready_in,
    output logic [PACKET_WIDTH-1:0] rt_data_out,
    input  logic                    rt_send_in,
    output logic                    rt_ready_out,
    input  logic [PACKET_WIDTH-1:0] rt_data_in,
    output logic                    pe_send_out,
    input  logic                    pe_ready_in,
    output logic [PACKET_WIDTH-1:0] pe_data_out,
    output logic [15:0]             inj_count,
    output logic [15:0]             ej_count,
    output logic [7:0]              misroute_count
);
    // Destination field layout: [3:2] = Y, [1:0] = X.
    localparam logic [3:0] LOCAL_DEST = {2'(LOCAL_Y), 2'(LOCAL_X)};

    // Index 0 = injection (PE -> router), index 1 = ejection (router -> PE).
    logic [1:0]              push_valid;
    logic [1:0]              push_ready;
    logic [1:0]              pop_valid;
    logic [1:0]              pop_ready;
    logic [PACKET_WIDTH-1:0] push_data [2];
    logic [PACKET_WIDTH-1:0] pop_data  [2];

    logic [15:0] inj_count_reg;
    logic [15:0] ej_count_reg;
    logic [7:0]  misroute_count_reg;
    logic        inj_pop;
    logic        ej_pop;
    logic        ej_push;
    logic        misrouted;

    assign push_valid[0] = pe_send_in;
    assign push_data[0]  = pe_data_in;
    assign pop_ready[0]  = rt_ready_in;
    assign pe_ready_out  = push_ready[0];
    assign rt_send_out   = pop_valid[0];
    assign rt_data_out   = pop_data[0];

    assign push_valid[1] = rt_send_in;
    assign push_data[1]  = rt_data_in;
    assign pop_ready[1]  = pe_ready_in;
    assign rt_ready_out  = push_ready[1];
    assign pe_send_out   = pop_valid[1];
    assign pe_data_out   = pop_data[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dir
            mesh_nic_fifo #(
                .WIDTH (PACKET_WIDTH),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk        (clk),
                .reset      (reset),
                .push_valid (push_valid[gi]),
                .push_ready (push_ready[gi]),
                .push_data  (push_data[gi]),
                .pop_valid  (pop_valid[gi]),
                .pop_ready  (pop_ready[gi]),
                .pop_data   (pop_data[gi])
            );
        end
    endgenerate

    assign inj_pop   = rt_send_out && rt_ready_in;
    assign ej_pop    = pe_send_out && pe_ready_in;
    assign ej_push   = rt_send_in && rt_ready_out;
    assign misrouted = (rt_data_in[3:0] != LOCAL_DEST);

    // Traffic counters: transfer counters wrap, misroute counter saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_count_reg      <= '0;
            ej_count_reg       <= '0;
            misroute_count_reg <= '0;
        end else begin
            if (inj_pop) inj_count_reg <= inj_count_reg + 16'd1;
            if (ej_pop)  ej_count_reg  <= ej_count_reg + 16'd1;
            if (ej_push && misrouted && misroute_count_reg != 8'hFF)
                misroute_count_reg <= misroute_count_reg + 8'd1;
        end
    end

    assign inj_count      = inj_count_reg;
    assign ej_count       = ej_count_reg;
    assign misroute_count = misroute_count_reg;
endmodule

// File: tb/tb_mesh_nic.sv
// Self-checking bench for mesh_nic (tile at X=1, Y=2). Source queues feed the
// PE and router sides, and accepted packets go into expected-output queues.
// The bench compares each DUT output transfer against the head of the matching
// expected queue.
module tb_mesh_nic;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pe_send_in = 1'b0;
    logic        pe_ready_out;
    logic [63:0] pe_data_in = '0;
    logic        rt_send_out;
    logic        rt_ready_in = 1'b0;
    logic [63:0] rt_data_out;
    logic        rt_send_in = 1'b0;
    logic        rt_ready_out;
    logic [63:0] rt_data_in = '0;
    logic        pe_send_out;
    logic        pe_ready_in = 1'b0;
    logic [63:0] pe_data_out;
    logic [15:0] inj_count;
    logic [15:0] ej_count;
    logic [7:0]  misroute_count;

    mesh_nic #(
        .PACKET_WIDTH (64),
        .FIFO_DEPTH   (4),
        .LOCAL_X      (1),
        .LOCAL_Y      (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pe_send_in     (pe_send_in),
        .pe_ready_out   (pe_ready_out),
        .pe_data_in     (pe_data_in),
        .rt_send_out    (rt_send_out),
        .rt_ready_in    (rt_ready_in),
        .rt_data_out    (rt_data_out),
        .rt_send_in     (rt_send_in),
        .rt_ready_out   (rt_ready_out),
        .rt_data_in     (rt_data_in),
        .pe_send_out    (pe_send_out),
        .pe_ready_in    (pe_ready_in),
        .pe_data_out    (pe_data_out),
        .inj_count      (inj_count),
        .ej_count       (ej_count),
        .misroute_count (misroute_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit verbose = 1'b1;
    bit inj_en = 1'b0, ej_en = 1'b0, rt_rdy = 1'b0, pe_rdy = 1'b0;
    logic [63:0] inj_src[$], inj_exp[$], ej_src[$], ej_exp[$];
    logic [15:0] inj_model = '0, ej_model = '0;
    logic [7:0]  mis_model = '0;
    int inj_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive from the sources at the falling edge, predict the
    // transfers of the coming rising edge, score them, then step to the next
    // falling edge.
    task automatic cycle();
        bit ip, io, ep, eo;
        logic [63:0] e;
        pe_send_in  = inj_en && (inj_src.size() > 0);
        pe_data_in  = pe_send_in ? inj_src[0] : 64'h0;
        rt_send_in  = ej_en && (ej_src.size() > 0);
        rt_data_in  = rt_send_in ? ej_src[0] : 64'h0;
        rt_ready_in = rt_rdy;
        pe_ready_in = pe_rdy;
        #1;
        ip = pe_send_in && pe_ready_out;
        io = rt_send_out && rt_ready_in;
        ep = rt_send_in && rt_ready_out;
        eo = pe_send_out && pe_ready_in;
        if (io) begin
            check("inj_pop_expected", 64'(inj_exp.size() > 0), 64'd1);
            if (inj_exp.size() > 0) begin
                e = inj_exp.pop_front();
                check("inj_data", rt_data_out, e);
            end
            inj_model++;
            inj_total++;
            if (verbose) $display("inj  router <- %h", rt_data_out);
        end
        if (ip) begin
            inj_exp.push_back(inj_src.pop_front());
            if (verbose) $display("inj  pe     -> %h", pe_data_in);
        end
        if (eo) begin
            check("ej_pop_expected", 64'(ej_exp.size() > 0), 64'd1);
            if (ej_exp.size() > 0) begin
                e = ej_exp.pop_front();
                check("ej_data", pe_data_out, e);
            end
            ej_model++;
            if (verbose) $display("ej   pe     <- %h", pe_data_out);
        end
        if (ep) begin
            if (rt_data_in[3:0] != 4'b1001 && mis_model != 8'hFF) mis_model++;
            ej_exp.push_back(ej_src.pop_front());
            if (verbose) $display("ej   router -> %h", rt_data_in);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && (inj_src.size() + inj_exp.size() + ej_src.size() + ej_exp.size()) > 0) begin
            cycle();
            n++;
        end
        check("drain_done", 64'(inj_src.size() + inj_exp.size() + ej_src.size() + ej_exp.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rt_send"},  64'(rt_send_out), 64'd0);
        check({tag, "_pe_send"},  64'(pe_send_out), 64'd0);
        check({tag, "_pe_ready"}, 64'(pe_ready_out), 64'd1);
        check({tag, "_rt_ready"}, 64'(rt_ready_out), 64'd1);
        check({tag, "_inj_cnt"},  64'(inj_count), 64'd0);
        check({tag, "_ej_cnt"},   64'(ej_count), 64'd0);
        check({tag, "_mis_cnt"},  64'(misroute_count), 64'd0);
        check({tag, "_rt_data"},  rt_data_out, 64'd0);
        check({tag, "_pe_data"},  pe_data_out, 64'd0);
    endtask

    initial begin
        // Reset then idle.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Injection streaming, back-to-back with the router always ready.
        rt_rdy = 1'b1;
        inj_en = 1'b1;
        for (int i = 1; i <= 8; i++) inj_src.push_back(64'(i));
        cycle();
        check("inj_latency_send", 64'(rt_send_out), 64'd1);
        check("inj_latency_data", rt_data_out, 64'd1);
        repeat (8) cycle();
        check("stream_inj_count", 64'(inj_count), 64'd8);
        check("stream_empty", 64'(rt_send_out), 64'd0);

        // Injection backpressure: 6 offered, 4 accepted.
        rt_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) inj_src.push_back(64'hB0 + 64'(i));
        repeat (6) cycle();
        check("bp_pe_ready", 64'(pe_ready_out), 64'd0);
        check("bp_accepted", 64'(inj_src.size()), 64'd2);
        check("bp_rt_send", 64'(rt_send_out), 64'd1);
        rt_rdy = 1'b1;
        cycle();
        check("bp_ready_after_pop", 64'(pe_ready_out), 64'd1);
        drain(50);
        check("bp_inj_count", 64'(inj_count), 64'(inj_model));

        // Ejection FIFO full, then simultaneous push and pop.
        pe_rdy = 1'b0;
        ej_en = 1'b1;
        for (int i = 1; i <= 5; i++) ej_src.push_back({60'hE0 + 60'(i), 4'b1001});
        repeat (4) cycle();
        check("ej_full_ready", 64'(rt_ready_out), 64'd0);
        check("ej_full_send", 64'(pe_send_out), 64'd1);
        pe_rdy = 1'b1;
        cycle();
        check("ej_simul_ready", 64'(rt_ready_out), 64'd1);
        pe_rdy = 1'b0;
        cycle();
        check("ej_refill_ready", 64'(rt_ready_out), 64'd0);
        pe_rdy = 1'b1;
        drain(50);
        check("ej_count_5", 64'(ej_count), 64'd5);
        check("ej_no_misroute", 64'(misroute_count), 64'd0);

        // Misroute detection at tile (1,2).
        ej_src.push_back({60'hA1, 4'b1001});
        drain(20);
        check("mis_local", 64'(misroute_count), 64'd0);
        ej_src.push_back({60'hA2, 4'b0001});
        drain(20);
        check("mis_remote", 64'(misroute_count), 64'd1);
        check("mis_ej_count", 64'(ej_count), 64'd7);

        // Misroute saturation.
        verbose = 1'b0;
        for (int i = 0; i < 300; i++) ej_src.push_back(64'(i) << 4);
        drain(400);
        check("mis_saturate", 64'(misroute_count), 64'd255);
        check("mis_sat_model", 64'(misroute_count), 64'(mis_model));
        check("ej_count_model", 64'(ej_count), 64'(ej_model));

        // Injection counter wrap after 65536 injections since reset.
        for (int i = inj_total; i < 65536; i++) inj_src.push_back(64'h7000_0000 + 64'(i));
        drain(70000);
        check("inj_wrap", 64'(inj_count), 64'd0);
        check("inj_wrap_model", 64'(inj_count), 64'(inj_model));
        verbose = 1'b1;

        // Reset asserted mid-traffic.
        rt_rdy = 1'b0;
        pe_rdy = 1'b0;
        for (int i = 1; i <= 3; i++) inj_src.push_back(64'hC0 + 64'(i));
        for (int i = 1; i <= 2; i++) ej_src.push_back({60'hD0 + 60'(i), 4'b1001});
        repeat (3) cycle();
        check("mid_pre_rt_send", 64'(rt_send_out), 64'd1);
        check("mid_pre_pe_send", 64'(pe_send_out), 64'd1);
        inj_en = 1'b0;
        ej_en = 1'b0;
        pe_send_in = 1'b0;
        rt_send_in = 1'b0;
        reset = 1'b1;
        #1;
        check_idle("midreset");
        inj_src.delete();
        inj_exp.delete();
        ej_src.delete();
        ej_exp.delete();
        inj_model = '0;
        ej_model = '0;
        mis_model = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mesh_nic.md
# mesh_nic

Network interface for one mesh tile: it connects a processing element (PE) to the local port of its router, using the same send/ready/data link protocol as the inter-router links. It buffers PE-injected packets into the router's local input and buffers router-ejected packets toward the PE. It also keeps injection, ejection and misroute counters. One instance sits beside each router of the 4x4 mesh.

## Interface
- PACKET_WIDTH, 64, link data width in bits
- FIFO_DEPTH, 4, entries per direction (power of 2, >= 2)
- LOCAL_X, 0, this tile's column (0-3)
- LOCAL_Y, 0, this tile's row (0-3)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pe_send_in  in  1  PE offers a packet for injection
- pe_ready_out  out  1  NIC can accept an injection packet
- pe_data_in  in  PACKET_WIDTH  injection packet
- rt_send_out  out  1  NIC offers a packet to the router local input
- rt_ready_in  in  1  router local input can accept
- rt_data_out  out  PACKET_WIDTH  packet to router
- rt_send_in  in  1  router offers an ejected packet
- rt_ready_out  out  1  NIC can accept an ejected packet
- rt_data_in  in  PACKET_WIDTH  packet from router
- pe_send_out  out  1  NIC offers an ejected packet to the PE
- pe_ready_in  in  1  PE can accept
- pe_data_out  out  PACKET_WIDTH  ejected packet to PE
- inj_count  out  16  packets handed to router, wraps modulo 2^16
- ej_count  out  16  packets handed to PE, wraps modulo 2^16
- misroute_count  out  8  ejected packets with wrong destination, saturates at 255

## Operation
- Link rule, on every link: one packet transfers on each rising edge where send && ready. Send and data are held stable until the transfer. Ready may change freely and never depends combinationally on send.
- Injection FIFO: push on pe_send_in && pe_ready_out; pop on rt_send_out && rt_ready_in.
  - pe_ready_out = !inj_full.
  - rt_send_out = !inj_empty.
  - rt_data_out = head entry.
- Ejection FIFO: push on rt_send_in && rt_ready_out; pop on pe_send_out && pe_ready_in.
  - rt_ready_out = !ej_full.
  - pe_send_out = !ej_empty.
  - pe_data_out = head entry.
- Each FIFO uses read/write pointers of log2(FIFO_DEPTH) bits that wrap, plus an occupancy count of log2(FIFO_DEPTH)+1 bits. Full means count == FIFO_DEPTH; empty means count == 0.
- Simultaneous push and pop:
  - Non-empty, non-full FIFO: count unchanged, both pointers advance.
  - Empty FIFO: only the push occurs. There is no bypass, because send is 0.
  - Full FIFO: only the pop occurs, because ready is 0. A freed slot becomes visible as ready on the next cycle.
- Destination field: bits [1:0] = dest X, bits [3:2] = dest Y. On each ejection push, if the field is not {LOCAL_Y, LOCAL_X}, misroute_count increments unless already 255. The packet is still buffered and delivered unmodified.
- inj_count increments on each injection pop. ej_count increments on each ejection pop. Both wrap 0xFFFF -> 0x0000.
- Packets are never dropped, reordered or modified in either direction.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - Pointers and counts are 0 and all counters are 0.
  - rt_send_out = 0, pe_send_out = 0.
  - pe_ready_out = 1, rt_ready_out = 1.
  - Data outputs are 0 while empty.
- Reset asserted mid-operation immediately empties both FIFOs and clears the counters. In-flight contents are discarded.
- Latency per direction: a packet accepted on edge N is offered (send = 1) in the cycle after edge N and can transfer on edge N+1 at the earliest.
- Throughput: one packet per cycle per direction while neither FIFO stalls.
- Backpressure: with the downstream ready held 0, a FIFO accepts exactly FIFO_DEPTH packets, then holds ready = 0.
- Outputs are functions of registered state only; there is no combinational path from any input to any output.

## Test plan
- Reset then idle:
  - Both send outputs are 0, both ready outputs are 1, all counters are 0.
  - Assert reset mid-traffic: same values in the same cycle.
- Injection streaming: PE sends 0x...0001 through 0x...0008 back-to-back with rt_ready_in = 1 -> rt_data_out shows the same sequence, each one cycle after acceptance, and inj_count = 8.
- Injection backpressure: rt_ready_in = 0 while the PE sends 6 packets -> 4 accepted, then pe_ready_out = 0. Release rt_ready_in -> 4 packets emerge in order, and pe_ready_out returns to 1 the cycle after the first pop.
- Full-FIFO simultaneous push/pop: with the ejection FIFO full, assert rt_send_in and pe_ready_in together -> in that cycle only the pop occurs; next cycle rt_ready_out = 1.
- Misroute: LOCAL_X = 1, LOCAL_Y = 2 -> eject packet with bits [3:0] = 4'b1001 (count unchanged), then 4'b0001 (misroute_count = 1). Both packets are delivered to the PE.
- Counter limits:
  - Force 65536 injections -> inj_count wraps to 0.
  - 300 misroutes -> misroute_count = 255.
